// File: rtl/qdma_desc_pkg.sv
// Shared types and defaults for the QDMA descriptor path (mux and credit gate).
package qdma_desc_pkg;

    localparam int NUM_Q    = 4;
    localparam int QID_W    = 2;
    localparam int DESC_W   = 128;
    localparam int CREDIT_W = 16;

    typedef logic [DESC_W-1:0]   desc_t;
    typedef logic [QID_W-1:0]    qid_t;
    typedef logic [CREDIT_W-1:0] credit_t;

    localparam credit_t CREDIT_MAX = '1;

endpackage

// File: rtl/qdma_credit_counter.sv
// Single-queue credit counter: saturating add of returned credits, decrement on
// consume, sticky overflow flag.
module qdma_credit_counter #(
    parameter int CREDIT_W = qdma_desc_pkg::CREDIT_W
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                dec,
    input  logic                add_en,
    input  logic [CREDIT_W-1:0] add_num,
    output logic [CREDIT_W-1:0] credit,
    output logic                ovf
);

    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] credit_d, credit_q;
    logic                ovf_d, ovf_q;

    // One extra bit holds the carry; dec is only raised when credit_q != 0,
    // so the subtraction never borrows out of the top bit.
    always_comb begin
        sum      = {1'b0, credit_q} + (add_en ? {1'b0, add_num} : '0)
                 - {{CREDIT_W{1'b0}}, dec};
        credit_d = sum[CREDIT_W-1:0];
        ovf_d    = ovf_q;
        if (sum[CREDIT_W]) begin
            credit_d = '1;
            ovf_d    = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments only; all next-state
    // math lives in the always_comb above.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign credit = credit_q;
    assign ovf    = ovf_q;

endmodule

// File: rtl/qdma_desc_credit_gate.sv
// Per-queue credit gate between the descriptor mux and the QDMA H2C bypass port.
// Registered output stage sustains one descriptor per cycle.
module qdma_desc_credit_gate #(
    parameter int NUM_Q    = qdma_desc_pkg::NUM_Q,
    parameter int QID_W    = qdma_desc_pkg::QID_W,
    parameter int DESC_W   = qdma_desc_pkg::DESC_W,
    parameter int CREDIT_W = qdma_desc_pkg::CREDIT_W
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                s_desc_valid,
    output logic                s_desc_ready,
    input  logic [QID_W-1:0]    s_desc_qid,
    input  logic [DESC_W-1:0]   s_desc_data,
    output logic                m_desc_valid,
    input  logic                m_desc_ready,
    output logic [QID_W-1:0]    m_desc_qid,
    output logic [DESC_W-1:0]   m_desc_data,
    input  logic                crd_valid,
    input  logic [QID_W-1:0]    crd_qid,
    input  logic [CREDIT_W-1:0] crd_num,
    input  logic [NUM_Q-1:0]    q_enable,
    output logic [NUM_Q-1:0]    credit_ovf,
    output logic [31:0]         stall_cnt
);

    logic [NUM_Q-1:0][CREDIT_W-1:0] credit;
    logic                           slot_free;
    logic                           accept;

    logic              m_valid_d, m_valid_q;
    logic [QID_W-1:0]  m_qid_d,   m_qid_q;
    logic [DESC_W-1:0] m_data_d,  m_data_q;
    logic [31:0]       stall_d,   stall_q;

    // Readiness looks only at registered credit, so a return is usable next cycle.
    assign slot_free    = !m_valid_q || m_desc_ready;
    assign s_desc_ready = slot_free && q_enable[s_desc_qid] && (credit[s_desc_qid] != '0);
    assign accept       = s_desc_valid && s_desc_ready;

    for (genvar q = 0; q < NUM_Q; q++) begin : g_cnt
        qdma_credit_counter #(.CREDIT_W(CREDIT_W)) u_cnt (
            .ACLK    (ACLK),
            .ARESET  (ARESET),
            .dec     (accept && (s_desc_qid == QID_W'(q))),
            .add_en  (crd_valid && (crd_qid == QID_W'(q))),
            .add_num (crd_num),
            .credit  (credit[q]),
            .ovf     (credit_ovf[q])
        );
    end

    always_comb begin
        m_valid_d = m_valid_q;
        m_qid_d   = m_qid_q;
        m_data_d  = m_data_q;
        stall_d   = stall_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_qid_d   = s_desc_qid;
            m_data_d  = s_desc_data;
        end else if (m_desc_ready) begin
            m_valid_d = 1'b0;
        end
        if (s_desc_valid && !s_desc_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    // NOTE: the payload register is reset too, so the output bus reads zero
    // after reset rather than stale data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_valid_q <= 1'b0;
            m_qid_q   <= '0;
            m_data_q  <= '0;
            stall_q   <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_qid_q   <= m_qid_d;
            m_data_q  <= m_data_d;
            stall_q   <= stall_d;
        end
    end

    assign m_desc_valid = m_valid_q;
    assign m_desc_qid   = m_qid_q;
    assign m_desc_data  = m_data_q;
    assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_qdma_desc_credit_gate.sv
// Randomised bench for qdma_desc_credit_gate against a queue-level credit model,
// plus directed scenarios with hand-computed expectations.
module tb_qdma_desc_credit_gate;
    import qdma_desc_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        s_desc_valid = 1'b0;
    logic        s_desc_ready;
    qid_t        s_desc_qid = '0;
    desc_t       s_desc_data = '0;
    logic        m_desc_valid;
    logic        m_desc_ready = 1'b0;
    qid_t        m_desc_qid;
    desc_t       m_desc_data;
    logic        crd_valid = 1'b0;
    qid_t        crd_qid = '0;
    credit_t     crd_num = '0;
    logic [NUM_Q-1:0] q_enable = '1;
    logic [NUM_Q-1:0] credit_ovf;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 ACLK = ~ACLK;

    qdma_desc_credit_gate dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .s_desc_valid (s_desc_valid),
        .s_desc_ready (s_desc_ready),
        .s_desc_qid   (s_desc_qid),
        .s_desc_data  (s_desc_data),
        .m_desc_valid (m_desc_valid),
        .m_desc_ready (m_desc_ready),
        .m_desc_qid   (m_desc_qid),
        .m_desc_data  (m_desc_data),
        .crd_valid    (crd_valid),
        .crd_qid      (crd_qid),
        .crd_num      (crd_num),
        .q_enable     (q_enable),
        .credit_ovf   (credit_ovf),
        .stall_cnt    (stall_cnt)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer credits per queue and one output slot.
    int unsigned      mdl_credit[NUM_Q] = '{default: 0};
    logic [NUM_Q-1:0] mdl_ovf = '0;
    logic             mdl_valid = 1'b0;
    qid_t             mdl_qid = '0;
    desc_t            mdl_data = '0;
    longint unsigned  mdl_stall = 0;

    function automatic logic exp_ready();
        return (!mdl_valid || m_desc_ready) && q_enable[s_desc_qid]
               && (mdl_credit[int'(s_desc_qid)] != 0);
    endfunction

    function automatic int unsigned credit_raw(int q);
        int unsigned add;
        int unsigned used;
        add  = (crd_valid && int'(crd_qid) == q) ? int'(crd_num) : 0;
        used = (s_desc_valid && exp_ready() && int'(s_desc_qid) == q) ? 1 : 0;
        return mdl_credit[q] + add - used;
    endfunction

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mdl_credit <= '{default: 0};
            mdl_ovf    <= '0;
            mdl_valid  <= 1'b0;
            mdl_qid    <= '0;
            mdl_data   <= '0;
            mdl_stall  <= 0;
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (credit_raw(q) > 65535) begin
                    mdl_credit[q] <= 65535;
                    mdl_ovf[q]    <= 1'b1;
                end else begin
                    mdl_credit[q] <= credit_raw(q);
                end
            end
            if (s_desc_valid && exp_ready()) begin
                mdl_valid <= 1'b1;
                mdl_qid   <= s_desc_qid;
                mdl_data  <= s_desc_data;
            end else if (m_desc_ready) begin
                mdl_valid <= 1'b0;
            end
            if (s_desc_valid && !exp_ready() && mdl_stall != 64'hFFFF_FFFF)
                mdl_stall <= mdl_stall + 1;
        end
    end

    // Compare process: 2 time units after each falling edge, inputs settled.
    always begin
        @(negedge ACLK);
        #2;
        if (!ARESET) begin
            check("s_desc_ready", 128'(s_desc_ready), 128'(exp_ready()));
            check("m_desc_valid", 128'(m_desc_valid), 128'(mdl_valid));
            if (mdl_valid) begin
                check("m_desc_qid", 128'(m_desc_qid), 128'(mdl_qid));
                check("m_desc_data", m_desc_data, mdl_data);
            end
            check("credit_ovf", 128'(credit_ovf), 128'(mdl_ovf));
            check("stall_cnt", 128'(stall_cnt), 128'(mdl_stall[31:0]));
        end
    end

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic give(input int q, input int n);
        crd_valid = 1'b1;
        crd_qid   = qid_t'(q);
        crd_num   = credit_t'(n);
        tick();
        crd_valid = 1'b0;
        crd_num   = '0;
    endtask

    function automatic desc_t rnd_desc();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        int    fwd;
        desc_t d0;

        repeat (2) tick();
        ARESET = 1'b0;
        check("reset m_desc_valid", 128'(m_desc_valid), 128'd0);
        check("reset m_desc_qid", 128'(m_desc_qid), 128'd0);
        check("reset m_desc_data", m_desc_data, 128'd0);
        check("reset credit_ovf", 128'(credit_ovf), 128'd0);
        check("reset stall_cnt", 128'(stall_cnt), 128'd0);

        // No credits anywhere: qid 1 stalls for 10 cycles.
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd1;
        repeat (10) tick();
        s_desc_valid = 1'b0;
        check("nocred stall_cnt", 128'(stall_cnt), 128'd10);
        check("nocred m_desc_valid", 128'(m_desc_valid), 128'd0);

        // Three credits on queue 2, five descriptors offered.
        m_desc_ready = 1'b1;
        give(2, 3);
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd2;
        fwd = 0;
        for (int i = 0; i < 5; i++) begin
            s_desc_data = desc_t'(i + 1);
            tick();
            fwd += int'(m_desc_valid);
        end
        s_desc_valid = 1'b0;
        repeat (2) begin
            tick();
            fwd += int'(m_desc_valid);
        end
        check("q2 forwarded", 128'(fwd), 128'd3);
        check("q2 stall_cnt", 128'(stall_cnt), 128'd12);

        // Backpressure on queue 0 with four credits.
        give(0, 4);
        m_desc_ready = 1'b0;
        d0           = rnd_desc();
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd0;
        s_desc_data  = d0;
        repeat (6) tick();
        check("bp m_desc_valid", 128'(m_desc_valid), 128'd1);
        check("bp m_desc_data held", m_desc_data, d0);
        check("bp stall_cnt", 128'(stall_cnt), 128'd17);
        m_desc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_desc_data = rnd_desc();
            tick();
        end
        s_desc_valid = 1'b0;
        tick();

        // Same-cycle return and consume on queue 3.
        give(3, 1);
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd3;
        s_desc_data  = rnd_desc();
        crd_valid    = 1'b1;
        crd_qid      = 2'd3;
        crd_num      = 16'd2;
        tick();
        crd_valid = 1'b0;
        crd_num   = '0;
        for (int i = 0; i < 3; i++) begin
            s_desc_data = rnd_desc();
            tick();
        end
        s_desc_valid = 1'b0;
        tick();
        check("q3 stall_cnt", 128'(stall_cnt), 128'd18);

        // Saturation on queue 1.
        give(1, 16'hFFFE);
        give(1, 5);
        check("sat credit_ovf", 128'(credit_ovf), 128'h2);
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd1;
        repeat (2) begin
            s_desc_data = rnd_desc();
            tick();
        end
        s_desc_valid = 1'b0;
        tick();
        check("sat ovf sticky", 128'(credit_ovf), 128'h2);

        // Disabled queue 0 holds its credits and stalls.
        give(0, 2);
        q_enable     = 4'b1110;
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd0;
        s_desc_data  = rnd_desc();
        repeat (3) tick();
        check("disabled m_desc_valid", 128'(m_desc_valid), 128'd0);
        check("disabled stall_cnt", 128'(stall_cnt), 128'd21);
        q_enable = '1;
        tick();
        check("reenable m_desc_valid", 128'(m_desc_valid), 128'd1);
        check("reenable m_desc_qid", 128'(m_desc_qid), 128'd0);
        s_desc_valid = 1'b0;
        tick();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s_desc_valid = ($urandom_range(0, 3) != 0);
            s_desc_qid   = qid_t'($urandom_range(0, NUM_Q - 1));
            s_desc_data  = rnd_desc();
            m_desc_ready = ($urandom_range(0, 3) != 0);
            crd_valid    = ($urandom_range(0, 2) == 0);
            crd_qid      = qid_t'($urandom_range(0, NUM_Q - 1));
            crd_num      = ($urandom_range(0, 63) == 0) ? credit_t'($urandom_range(0, 65535))
                                                        : credit_t'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) q_enable = NUM_Q'($urandom);
            tick();
        end

        // Reset asserted while a descriptor is held.
        s_desc_valid = 1'b0;
        crd_valid    = 1'b0;
        q_enable     = '1;
        give(2, 1);
        m_desc_ready = 1'b0;
        s_desc_valid = 1'b1;
        s_desc_qid   = 2'd2;
        s_desc_data  = rnd_desc();
        tick();
        check("pre-reset m_desc_valid", 128'(m_desc_valid), 128'd1);
        #1 ARESET = 1'b1;
        #1;
        check("async reset m_desc_valid", 128'(m_desc_valid), 128'd0);
        check("async reset stall_cnt", 128'(stall_cnt), 128'd0);
        check("async reset credit_ovf", 128'(credit_ovf), 128'd0);
        s_desc_valid = 1'b0;
        tick();
        ARESET = 1'b0;
        s_desc_valid = 1'b1;
        repeat (3) tick();
        check("post-reset stall_cnt", 128'(stall_cnt), 128'd3);
        s_desc_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
